// File: rtl/rob_commit_if.sv
// BTB write port between the commit stage (master) and the BTB (slave).
// Request is held until btb_req & btb_ack.
interface rob_commit_if #(
  parameter int IDX_W = 9,
  parameter int DAT_W = 129
);
  logic             btb_req;
  logic [IDX_W-1:0] btb_idx;
  logic [DAT_W-1:0] btb_wmask;
  logic [DAT_W-1:0] btb_din;
  logic             btb_ack;

  modport master (output btb_req, btb_idx, btb_wmask, btb_din, input btb_ack);
  modport slave  (input btb_req, btb_idx, btb_wmask, btb_din, output btb_ack);
endinterface

// File: rtl/rob_commit.sv
// ROB commit stage: retires the head entry when ready; commit_vld is combinational, RAT/free/BHT updates follow one cycle later.
// Backpressure: a head entry with a BTB write stalls while the one-deep BTB buffer is full and not being acked.
module rob_commit #(
  parameter int ROB_DEPTH = 64,
  parameter int PTR_W     = 6,
  parameter int LREG_W    = 5,
  parameter int PREG_W    = 6,
  parameter int BHT_IDX_W = 9
) (
  input  logic                 clock,
  input  logic                 reset,
  output logic [PTR_W:0]       head_ptr,
  input  logic                 head_ready,
  input  logic                 head_need_to_wb,
  input  logic [LREG_W-1:0]    head_lrd,
  input  logic [PREG_W-1:0]    head_prd,
  input  logic [PREG_W-1:0]    head_old_prd,
  input  logic                 head_bht_we,
  input  logic [BHT_IDX_W-1:0] head_bht_idx,
  input  logic [1:0]           head_bht_sel,
  input  logic                 head_bht_inc,
  input  logic                 head_bht_dec,
  input  logic                 head_btb_we,
  input  logic [8:0]           head_btb_idx,
  input  logic [128:0]         head_btb_wmask,
  input  logic [128:0]         head_btb_din,
  output logic                 commit_vld,
  input  logic                 flush_vld,
  output logic                 arat_we,
  output logic [LREG_W-1:0]    arat_lrd,
  output logic [PREG_W-1:0]    arat_prd,
  output logic                 free_vld,
  output logic [PREG_W-1:0]    free_preg,
  output logic                 bht_we,
  output logic [BHT_IDX_W-1:0] bht_idx,
  output logic [1:0]           bht_sel,
  output logic                 bht_inc,
  output logic                 bht_dec,
  rob_commit_if.master         btb,
  output logic [63:0]          retire_cnt
);

  typedef enum logic {BTB_EMPTY, BTB_FULL} btb_state_t;

  btb_state_t     btb_state;
  btb_state_t     btb_state_nxt;
  logic           btb_free;
  logic           btb_fire;
  logic           rat_write;
  logic [8:0]     btb_idx_q;
  logic [128:0]   btb_wmask_q;
  logic [128:0]   btb_din_q;
  logic [PTR_W-1:0] head_idx;

  assign head_idx  = head_ptr[PTR_W-1:0];
  assign rat_write = commit_vld & head_need_to_wb & (head_lrd != '0);

  always_comb begin
    btb_state_nxt = btb_state;
    btb_free      = (btb_state == BTB_EMPTY) | btb.btb_ack;
    commit_vld    = head_ready & ~flush_vld & (~head_btb_we | btb_free);
    btb_fire      = commit_vld & head_btb_we;
    case (btb_state)
      BTB_EMPTY: if (btb_fire) btb_state_nxt = BTB_FULL;
      // an ack in the same cycle as a new BTB retirement refills the buffer
      BTB_FULL:  if (btb.btb_ack && !btb_fire) btb_state_nxt = BTB_EMPTY;
      default:   btb_state_nxt = BTB_EMPTY;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      btb_state <= BTB_EMPTY;
    end else begin
      btb_state <= btb_state_nxt;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      btb_idx_q   <= '0;
      btb_wmask_q <= '0;
      btb_din_q   <= '0;
    end else if (btb_fire) begin
      btb_idx_q   <= head_btb_idx;
      btb_wmask_q <= head_btb_wmask;
      btb_din_q   <= head_btb_din;
    end
  end

  assign btb.btb_req   = (btb_state == BTB_FULL);
  assign btb.btb_idx   = btb_idx_q;
  assign btb.btb_wmask = btb_wmask_q;
  assign btb.btb_din   = btb_din_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      head_ptr   <= '0;
      retire_cnt <= '0;
    end else if (commit_vld) begin
      retire_cnt <= retire_cnt + 64'd1;
      if (head_idx == PTR_W'(ROB_DEPTH - 1)) begin
        head_ptr <= {~head_ptr[PTR_W], {PTR_W{1'b0}}};
      end else begin
        head_ptr <= {head_ptr[PTR_W], head_idx + PTR_W'(1)};
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      arat_we   <= 1'b0;
      arat_lrd  <= '0;
      arat_prd  <= '0;
      free_vld  <= 1'b0;
      free_preg <= '0;
      bht_we    <= 1'b0;
      bht_idx   <= '0;
      bht_sel   <= '0;
      bht_inc   <= 1'b0;
      bht_dec   <= 1'b0;
    end else begin
      arat_we  <= rat_write;
      free_vld <= rat_write;
      bht_we   <= commit_vld & head_bht_we;
      if (rat_write) begin
        arat_lrd  <= head_lrd;
        arat_prd  <= head_prd;
        free_preg <= head_old_prd;
      end
      if (commit_vld) begin
        bht_idx <= head_bht_idx;
        bht_sel <= head_bht_sel;
        bht_inc <= head_bht_inc;
        bht_dec <= head_bht_dec;
      end
    end
  end

endmodule
